// File: rtl/clock_pkg.sv
// clock_pkg: shared types and constants for the time-of-day counter.
//   mode_e     : set_sel decode (RUN / SET_HOUR / SET_MIN / CLR_SEC)
//   bcd_t      : packed two-digit BCD byte
//   *_MOD      : field moduli
//   to_bcd     : small integer -> BCD byte (elaboration-time constants)
//   bcd_inc    : BCD increment with wrap at a modulus
package clock_pkg;

  typedef logic [7:0] bcd_t;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'b00,
    MODE_SET_HOUR = 2'b01,
    MODE_SET_MIN  = 2'b10,
    MODE_CLR_SEC  = 2'b11
  } mode_e;

  localparam int unsigned SEC_MOD  = 60;
  localparam int unsigned MIN_MOD  = 60;
  localparam int unsigned HOUR_MOD = 24;

  function automatic bcd_t to_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Wrap is decided on the full BCD byte, not on a binary count.
  function automatic bcd_t bcd_inc(input bcd_t v, input int unsigned m);
    if (v == to_bcd(m - 1))
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter wrapping at MOD.
//   clk_50mhz, rst_n : clock, async active-low reset
//   inc              : increment this cycle
//   clr              : force to 00 (wins over inc)
//   q                : registered BCD value
//   carry            : combinational, inc while q == MOD-1
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int unsigned MOD = 60
) (
  input  logic clk_50mhz,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output bcd_t q,
  output logic carry
);

  bcd_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)
      q_d = 8'h00;
    else if (inc)
      q_d = bcd_inc(q_q, MOD);
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) q_q <= 8'h00;
    else        q_q <= q_d;
  end

  assign q     = q_q;
  assign carry = inc && (q_q == to_bcd(MOD - 1));

endmodule

// File: rtl/time_counter.sv
// time_counter: hh:mm:ss BCD time-of-day counter with hour/minute set modes.
//   clk_50mhz, rst_n  : clock, async active-low reset
//   clk1hz            : 1 Hz square wave, synchronized and edge-detected
//   set_sel           : 00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 CLR_SEC
//   inc_pulse         : one-cycle increment request for the selected field
//   hour/min/sec_bcd  : registered BCD time
//   hour_pulse        : one cycle when RUN carries into a new hour
// Optional (macro TIME_ALARM_EN): alarm_hour_bcd, alarm_min_bcd inputs and
// registered alarm_hit pulse on the RUN transition into alarm hh:mm:00.
module time_counter
  import clock_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_50mhz,
  input  logic       rst_n,
  input  logic       clk1hz,
  input  logic [1:0] set_sel,
  input  logic       inc_pulse,
`ifdef TIME_ALARM_EN
  input  logic [7:0] alarm_hour_bcd,
  input  logic [7:0] alarm_min_bcd,
  output logic       alarm_hit,
`endif
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       hour_pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic [2:0]             fill_q, fill_d;
  logic                   hour_pulse_q, hour_pulse_d;
  logic                   tick;
  mode_e                  mode;
  logic                   run;
  logic                   sec_inc, min_inc, hour_inc;
  logic                   sec_carry, min_carry, hour_carry_unused;

  assign mode = mode_e'(set_sel);
  assign run  = (mode == MODE_RUN);

  // fill_q holds off edge detection until the chain and edge_q have all
  // loaded post-reset data, so a clk1hz that is already high at release
  // does not look like a rising edge.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], clk1hz};
    edge_d = sync_q[SYNC_STAGES-1];
    fill_d = (fill_q == 3'd0) ? 3'd0 : fill_q - 3'd1;
  end

  assign tick = sync_q[SYNC_STAGES-1] && !edge_q && (fill_q == 3'd0);

  assign sec_inc  = run && tick;
  assign min_inc  = (run && sec_carry) || ((mode == MODE_SET_MIN)  && inc_pulse);
  assign hour_inc = (run && min_carry) || ((mode == MODE_SET_HOUR) && inc_pulse);

  // min_carry only occurs in RUN via a seconds carry, i.e. a true hour rollover.
  assign hour_pulse_d = run && min_carry;

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      edge_q       <= 1'b0;
      fill_q       <= 3'(SYNC_STAGES + 1);
      hour_pulse_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      edge_q       <= edge_d;
      fill_q       <= fill_d;
      hour_pulse_q <= hour_pulse_d;
    end
  end

  bcd_mod_counter #(.MOD(SEC_MOD)) u_sec (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .inc       (sec_inc),
    .clr       (mode == MODE_CLR_SEC),
    .q         (sec_bcd),
    .carry     (sec_carry)
  );

  bcd_mod_counter #(.MOD(MIN_MOD)) u_min (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .inc       (min_inc),
    .clr       (1'b0),
    .q         (min_bcd),
    .carry     (min_carry)
  );

  bcd_mod_counter #(.MOD(HOUR_MOD)) u_hour (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .inc       (hour_inc),
    .clr       (1'b0),
    .q         (hour_bcd),
    .carry     (hour_carry_unused)
  );

  assign hour_pulse = hour_pulse_q;

`ifdef TIME_ALARM_EN
  logic alarm_hit_q, alarm_hit_d;
  bcd_t min_next, hour_next;

  // Look at the values the counters are about to load so the pulse lines up
  // with the cycle the display shows alarm hh:mm:00.
  always_comb begin
    min_next    = bcd_inc(min_bcd, MIN_MOD);
    hour_next   = min_carry ? bcd_inc(hour_bcd, HOUR_MOD) : hour_bcd;
    alarm_hit_d = run && sec_carry &&
                  (min_next == alarm_min_bcd) && (hour_next == alarm_hour_bcd);
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) alarm_hit_q <= 1'b0;
    else        alarm_hit_q <= alarm_hit_d;
  end

  assign alarm_hit = alarm_hit_q;
`endif

endmodule

// File: tb/tb_time_counter.sv
module tb_time_counter;

  logic       clk_50mhz = 1'b0;
  logic       rst_n     = 1'b0;
  logic       clk1hz    = 1'b0;
  logic [1:0] set_sel   = 2'b00;
  logic       inc_pulse = 1'b0;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;
  logic       hour_pulse;
`ifdef TIME_ALARM_EN
  logic [7:0] alarm_hour_bcd = 8'h07;
  logic [7:0] alarm_min_bcd  = 8'h30;
  logic       alarm_hit;
  int         alarm_cnt = 0;
`endif

  int total = 0;
  int bad   = 0;
  logic [24:0] exp_q[$];
  bit          mon_en = 1'b0;
  logic [24:0] prev_obs;
  int mh = 0, mm = 0, ms = 0;

  time_counter #(.SYNC_STAGES(2)) dut (
    .clk_50mhz      (clk_50mhz),
    .rst_n          (rst_n),
    .clk1hz         (clk1hz),
    .set_sel        (set_sel),
    .inc_pulse      (inc_pulse),
`ifdef TIME_ALARM_EN
    .alarm_hour_bcd (alarm_hour_bcd),
    .alarm_min_bcd  (alarm_min_bcd),
    .alarm_hit      (alarm_hit),
`endif
    .hour_bcd       (hour_bcd),
    .min_bcd        (min_bcd),
    .sec_bcd        (sec_bcd),
    .hour_pulse     (hour_pulse)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  function automatic logic [7:0] tob(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [24:0] pack(input int h, input int m, input int s, input logic hp);
    return {tob(h), tob(m), tob(s), hp};
  endfunction

  function automatic logic [24:0] observed();
    return {hour_bcd, min_bcd, sec_bcd, hour_pulse};
  endfunction

  task automatic check(input string name, input logic [24:0] got, input logic [24:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h required=%h (hh mm ss hp)", name, got, exp);
    end
  endtask

  // Monitor: every change on the outputs must match the next queued state.
  always @(negedge clk_50mhz) begin
    logic [24:0] cur;
    cur = observed();
    if (!mon_en) prev_obs = cur;
    else if (cur !== prev_obs) begin
      prev_obs = cur;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_change got=%h required=no_change", cur);
      end else begin
        check("scoreboard", cur, exp_q.pop_front());
      end
    end
  end

`ifdef TIME_ALARM_EN
  always @(negedge clk_50mhz) if (rst_n && alarm_hit) alarm_cnt++;
`endif

  task automatic pulse_1hz();
    clk1hz = 1'b1;
    repeat (8) @(posedge clk_50mhz);
    #1 clk1hz = 1'b0;
    repeat (8) @(posedge clk_50mhz);
    #1;
  endtask

  task automatic run_ticks(input int n);
    bit hp;
    for (int i = 0; i < n; i++) begin
      hp = 1'b0;
      ms++;
      if (ms == 60) begin
        ms = 0;
        mm++;
        if (mm == 60) begin
          mm = 0;
          hp = 1'b1;
          mh++;
          if (mh == 24) mh = 0;
        end
      end
      if (hp) exp_q.push_back(pack(mh, mm, ms, 1'b1));
      exp_q.push_back(pack(mh, mm, ms, 1'b0));
      pulse_1hz();
    end
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) pulse_1hz();
  endtask

  // field: 1 = hours, 2 = minutes, 0 = expect no effect
  task automatic inc_n(input int field, input int n);
    for (int i = 0; i < n; i++) begin
      if (field == 1) begin mh = (mh + 1) % 24; exp_q.push_back(pack(mh, mm, ms, 1'b0)); end
      if (field == 2) begin mm = (mm + 1) % 60; exp_q.push_back(pack(mh, mm, ms, 1'b0)); end
      inc_pulse = 1'b1;
      @(posedge clk_50mhz); #1;
      inc_pulse = 1'b0;
      @(posedge clk_50mhz); #1;
    end
  endtask

  task automatic set_mode(input logic [1:0] m);
    if (m == 2'b11 && ms != 0) begin
      ms = 0;
      exp_q.push_back(pack(mh, mm, ms, 1'b0));
    end
    set_sel = m;
    repeat (2) @(posedge clk_50mhz);
    #1;
  endtask

  task automatic check_now(input string name);
    check(name, observed(), pack(mh, mm, ms, 1'b0));
  endtask

  initial begin
    // Reset with clk1hz toggling: outputs stay at zero.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      clk1hz = ~clk1hz;
      repeat (5) @(posedge clk_50mhz);
      @(negedge clk_50mhz);
      check("reset_outputs", observed(), 25'h0);
`ifdef TIME_ALARM_EN
      check("reset_alarm", {24'h0, alarm_hit}, 25'h0);
`endif
    end
    // Release with clk1hz high: no tick without a real edge.
    @(posedge clk_50mhz); #1 clk1hz = 1'b1;
    @(posedge clk_50mhz); #1 rst_n = 1'b1;
    repeat (12) @(posedge clk_50mhz); #1;
    check_now("release_high_no_tick");
    clk1hz = 1'b0;
    repeat (8) @(posedge clk_50mhz); #1;
    mon_en = 1'b1;
    @(posedge clk_50mhz); #1;

    run_ticks(58);
    check_now("preset_00_00_58");
    run_ticks(2);
    check_now("run_to_00_01_00");

    // inc_pulse ignored in RUN
    inc_n(0, 3);

    set_mode(2'b10);
    inc_n(2, 58);
    idle_ticks(2);
    check_now("set_min_ticks_ignored");
    set_mode(2'b00);
    run_ticks(59);
    run_ticks(1);
    check_now("hour_carry_01_00_00");

    set_mode(2'b01);
    inc_n(2 - 2, 0);
    inc_n(1, 22);
    idle_ticks(1);
    check_now("set_hour_ticks_ignored");
    set_mode(2'b10);
    inc_n(2, 59);
    set_mode(2'b00);
    run_ticks(59);
    run_ticks(1);
    check_now("day_wrap_00_00_00");

    set_mode(2'b10);
    inc_n(2, 59);
    set_mode(2'b01);
    inc_n(1, 23);
    inc_n(1, 1);
    check_now("set_hour_23_wrap");
    inc_n(1, 5);
    set_mode(2'b10);
    inc_n(2, 1);
    check_now("set_min_59_wrap");

    // Back-to-back inc_pulse counts twice.
    mm = mm + 1; exp_q.push_back(pack(mh, mm, ms, 1'b0));
    mm = mm + 1; exp_q.push_back(pack(mh, mm, ms, 1'b0));
    inc_pulse = 1'b1;
    repeat (2) @(posedge clk_50mhz);
    #1 inc_pulse = 1'b0;
    @(posedge clk_50mhz); #1;
    check_now("back_to_back_inc");

    set_mode(2'b01);
    inc_n(1, 7);
    set_mode(2'b10);
    inc_n(2, 32);
    set_mode(2'b00);
    run_ticks(45);
    check_now("at_12_34_45");
    set_mode(2'b11);
    check_now("clr_sec_zero");
    inc_n(0, 2);
    idle_ticks(3);
    check_now("clr_sec_holds");
    set_mode(2'b00);
    run_ticks(1);
    check_now("resume_12_34_01");

`ifdef TIME_ALARM_EN
    set_mode(2'b01);
    inc_n(1, 19);
    set_mode(2'b10);
    inc_n(2, 55);
    set_mode(2'b00);
    run_ticks(58);
    check_now("at_07_29_59");
    check("alarm_quiet_before", 25'(alarm_cnt), 25'd0);
    run_ticks(1);
    check("alarm_single_pulse", 25'(alarm_cnt), 25'd1);
    run_ticks(1);
    check("alarm_no_refire", 25'(alarm_cnt), 25'd1);
`endif

    repeat (20) @(posedge clk_50mhz);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_expected got=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
